// File: rtl/audio_clk_rate_ctrl_if.sv
// Configuration handshake between the register block and the audio clock
// rate-change sequencer.
interface audio_clk_rate_ctrl_if #(
  parameter int N = 8
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_bclk_max;
  logic [N-1:0] cfg_lrck_max;

  modport master (output cfg_valid, cfg_bclk_max, cfg_lrck_max, input cfg_ready);
  modport slave  (input cfg_valid, cfg_bclk_max, cfg_lrck_max, output cfg_ready);
endinterface

// File: rtl/audio_clk_rate_ctrl.sv
// Sequences BCLK/LRCLK divider rate changes: waits for an LRCLK frame boundary,
// holds both dividers in reset while their terminal counts change, then releases.
module audio_clk_rate_ctrl #(
  parameter int N            = 8,
  parameter int DEF_BCLK_MAX = 3,
  parameter int DEF_LRCK_MAX = 127,
  parameter int HOLD_CYCLES  = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                     clk_clkin,
  input  logic                     reset_n,
  audio_clk_rate_ctrl_if.slave     cfg,
  input  logic                     lrck_q,
  output logic                     div_rst_n,
  output logic [N-1:0]             bclk_max,
  output logic [N-1:0]             lrck_max,
  output logic                     switching,
  output logic                     done,
  output logic                     timeout_err
);

  localparam logic [N-1:0] DEF_B     = N'(DEF_BCLK_MAX);
  localparam logic [N-1:0] DEF_L     = N'(DEF_LRCK_MAX);
  localparam logic [7:0]   HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0]  TO_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;

  state_t       state;
  logic [7:0]   hold_cnt;
  logic [15:0]  to_cnt;
  logic [N-1:0] pend_b, pend_l;
  logic         lrck_d;
  logic         startup;
  logic         fe;
  logic         same;

  assign fe   = lrck_d & ~lrck_q;
  assign same = (cfg.cfg_bclk_max == bclk_max) && (cfg.cfg_lrck_max == lrck_max);

  always_ff @(posedge clk_clkin or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HOLD;
      hold_cnt      <= '0;
      to_cnt        <= '0;
      div_rst_n     <= 1'b0;
      bclk_max      <= DEF_B;
      lrck_max      <= DEF_L;
      pend_b        <= DEF_B;
      pend_l        <= DEF_L;
      cfg.cfg_ready <= 1'b0;
      switching     <= 1'b1;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      lrck_d        <= 1'b0;
      startup       <= 1'b1;
    end else begin
      lrck_d <= lrck_q;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_valid && cfg.cfg_ready) begin
            pend_b      <= cfg.cfg_bclk_max;
            pend_l      <= cfg.cfg_lrck_max;
            timeout_err <= 1'b0;
            if (same) begin
              done <= 1'b1;
            end else begin
              state         <= DRAIN;
              to_cnt        <= '0;
              cfg.cfg_ready <= 1'b0;
              switching     <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (to_cnt != TO_LAST) to_cnt <= to_cnt + 16'd1;
          // Frame boundary wins over a coincident timeout.
          if (fe || (to_cnt == TO_LAST)) begin
            if (!fe) timeout_err <= 1'b1;
            state     <= HOLD;
            div_rst_n <= 1'b0;
            bclk_max  <= pend_b;
            lrck_max  <= pend_l;
            hold_cnt  <= '0;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) begin
            state         <= IDLE;
            div_rst_n     <= 1'b1;
            cfg.cfg_ready <= 1'b1;
            switching     <= 1'b0;
            done          <= ~startup;
            startup       <= 1'b0;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_clk_rate_ctrl.sv
// Directed bench for audio_clk_rate_ctrl; done pulses are checked against a
// queue of expected applied configurations.
module tb_audio_clk_rate_ctrl;

  logic       clk_clkin;
  logic       reset_n;
  logic       lrck_q;
  logic       div_rst_n;
  logic [7:0] bclk_max;
  logic [7:0] lrck_max;
  logic       switching;
  logic       done;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] b;
    logic [7:0] l;
    logic       tmo;
    int         hold;
  } exp_t;

  exp_t exp_q[$];

  audio_clk_rate_ctrl_if #(.N(8)) cfg_bus();

  audio_clk_rate_ctrl #(
    .N(8), .DEF_BCLK_MAX(3), .DEF_LRCK_MAX(127), .HOLD_CYCLES(4), .TIMEOUT(16)
  ) dut (
    .clk_clkin   (clk_clkin),
    .reset_n     (reset_n),
    .cfg         (cfg_bus),
    .lrck_q      (lrck_q),
    .div_rst_n   (div_rst_n),
    .bclk_max    (bclk_max),
    .lrck_max    (lrck_max),
    .switching   (switching),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial begin
    clk_clkin = 1'b0;
    forever #5 clk_clkin = ~clk_clkin;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected configuration,
  // including how many cycles the dividers were held in reset for it.
  initial begin
    int lowrun;
    exp_t e;
    lowrun = 0;
    forever begin
      @(posedge clk_clkin);
      #1;
      if (!reset_n) begin
        lowrun = 0;
      end else begin
        if (!div_rst_n) lowrun++;
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_bclk", bclk_max, e.b);
            chk("sb_lrck", lrck_max, e.l);
            chk("sb_timeout_err", timeout_err, e.tmo);
            chk("sb_hold_len", lowrun, e.hold);
          end
        end
        if (cfg_bus.cfg_ready) lowrun = 0;
      end
    end
  end

  task automatic startup_check(input string tag);
    int n;
    n = 0;
    while (div_rst_n == 1'b0 && n < 20) begin
      @(posedge clk_clkin);
      #1;
      n++;
    end
    chk({tag, "_hold_len"}, n, 4);
    chk({tag, "_ready"}, cfg_bus.cfg_ready, 1);
    chk({tag, "_switching"}, switching, 0);
    chk({tag, "_bclk"}, bclk_max, 3);
    chk({tag, "_lrck"}, lrck_max, 127);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!cfg_bus.cfg_ready && n < 60) begin
      @(posedge clk_clkin);
      #1;
      n++;
    end
    chk(name, cfg_bus.cfg_ready, 1);
  endtask

  task automatic offer(input logic [7:0] b, input logic [7:0] l);
    @(negedge clk_clkin);
    cfg_bus.cfg_valid    = 1'b1;
    cfg_bus.cfg_bclk_max = b;
    cfg_bus.cfg_lrck_max = l;
  endtask

  initial begin
    int n;
    reset_n              = 1'b0;
    lrck_q               = 1'b0;
    cfg_bus.cfg_valid    = 1'b0;
    cfg_bus.cfg_bclk_max = '0;
    cfg_bus.cfg_lrck_max = '0;
    repeat (3) @(posedge clk_clkin);
    #1;
    chk("rst_div_rst_n", div_rst_n, 0);
    chk("rst_ready", cfg_bus.cfg_ready, 0);
    chk("rst_switching", switching, 1);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_bclk", bclk_max, 3);
    chk("rst_lrck", lrck_max, 127);

    @(negedge clk_clkin);
    reset_n = 1'b1;
    startup_check("startup");

    // Identical configuration: no divider reset, done right after accept.
    offer(8'd3, 8'd127);
    exp_q.push_back('{8'd3, 8'd127, 1'b0, 0});
    @(posedge clk_clkin);
    #1;
    chk("ident_done", done, 1);
    chk("ident_div_rst_n", div_rst_n, 1);
    chk("ident_switching", switching, 0);
    @(negedge clk_clkin);
    cfg_bus.cfg_valid = 1'b0;

    // Normal 1/63 switch with 9/9 held on the bus while busy.
    offer(8'd1, 8'd63);
    exp_q.push_back('{8'd1, 8'd63, 1'b0, 4});
    exp_q.push_back('{8'd9, 8'd9, 1'b0, 4});
    @(posedge clk_clkin);
    #1;
    chk("sw_accept_ready", cfg_bus.cfg_ready, 0);
    chk("sw_accept_switching", switching, 1);
    @(negedge clk_clkin);
    cfg_bus.cfg_bclk_max = 8'd9;
    cfg_bus.cfg_lrck_max = 8'd9;
    @(negedge clk_clkin);
    lrck_q = 1'b1;
    repeat (2) @(negedge clk_clkin);
    chk("sw_drain_div_rst_n", div_rst_n, 1);
    chk("sw_drain_bclk", bclk_max, 3);
    lrck_q = 1'b0;
    @(posedge clk_clkin);
    #1;
    chk("sw_fe_div_rst_n", div_rst_n, 0);
    chk("sw_fe_bclk", bclk_max, 1);
    chk("sw_fe_lrck", lrck_max, 63);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk_clkin);
      #1;
      n++;
    end
    chk("sw_done_edges", n, 4);
    chk("sw_done_ready", cfg_bus.cfg_ready, 1);
    @(posedge clk_clkin);
    #1;
    chk("busy_accept_ready", cfg_bus.cfg_ready, 0);
    chk("busy_accept_switching", switching, 1);
    chk("busy_bclk_kept", bclk_max, 1);
    @(negedge clk_clkin);
    cfg_bus.cfg_valid = 1'b0;
    lrck_q = 1'b1;
    repeat (2) @(negedge clk_clkin);
    lrck_q = 1'b0;
    wait_ready("busy_idle");

    // Timeout: no frame boundary while draining.
    offer(8'd7, 8'd31);
    exp_q.push_back('{8'd7, 8'd31, 1'b1, 4});
    @(posedge clk_clkin);
    #1;
    @(negedge clk_clkin);
    cfg_bus.cfg_valid = 1'b0;
    n = 0;
    while (div_rst_n && n < 100) begin
      @(posedge clk_clkin);
      #1;
      n++;
    end
    chk("to_drain_cycles", n, 16);
    chk("to_err_set", timeout_err, 1);
    chk("to_bclk", bclk_max, 7);
    wait_ready("to_idle");
    chk("to_err_sticky", timeout_err, 1);

    offer(8'd7, 8'd31);
    exp_q.push_back('{8'd7, 8'd31, 1'b0, 0});
    @(posedge clk_clkin);
    #1;
    chk("to_err_cleared", timeout_err, 0);
    @(negedge clk_clkin);
    cfg_bus.cfg_valid = 1'b0;

    // Reset in the middle of DRAIN discards the pending configuration.
    offer(8'd2, 8'd5);
    @(posedge clk_clkin);
    #1;
    chk("rd_switching", switching, 1);
    @(negedge clk_clkin);
    cfg_bus.cfg_valid = 1'b0;
    repeat (3) @(negedge clk_clkin);
    reset_n = 1'b0;
    #1;
    chk("rd_bclk", bclk_max, 3);
    chk("rd_lrck", lrck_max, 127);
    chk("rd_div_rst_n", div_rst_n, 0);
    chk("rd_ready", cfg_bus.cfg_ready, 0);
    @(negedge clk_clkin);
    reset_n = 1'b1;
    startup_check("rd_startup");

    repeat (10) @(posedge clk_clkin);
    #1;
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_clk_rate_ctrl.md
Name: audio_clk_rate_ctrl

Overview:
- Rate-change sequencer for the audio clock divider pair (BCLK divider and LRCLK divider) in the audio clock mux IP.
- Accepts new divider terminal counts over a valid/ready handshake and waits for an LRCLK frame boundary.
- Holds both dividers in reset while their max_count inputs change, then releases them so the new rate starts glitch-free and phase-aligned.
- Sits between the register/control interface and the divider instances.

Parameters:
- N, 8: width of divider max_count values.
- DEF_BCLK_MAX, 3: bclk_max value after reset.
- DEF_LRCK_MAX, 127: lrck_max value after reset.
- HOLD_CYCLES, 4: cycles div_rst_n is held low per switch (1..255).
- TIMEOUT, 1024: DRAIN cycles allowed before a forced switch (2..65535).

Ports:
- clk_clkin  in  1  master audio clock; same clock that drives the dividers.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  controller can accept a configuration (IDLE only).
- cfg_bclk_max  in  N  requested BCLK divider terminal count.
- cfg_lrck_max  in  N  requested LRCLK divider terminal count.
- lrck_q  in  1  q output of the LRCLK divider; same clock domain, no synchroniser.
- div_rst_n  out  1  active-low reset to both dividers; registered.
- bclk_max  out  N  max_count to the BCLK divider.
- lrck_max  out  N  max_count to the LRCLK divider.
- switching  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a configuration is applied.
- timeout_err  out  1  sticky; last switch was forced by timeout.

Behaviour:
- Reset (reset_n low, async) drives:
  - state=HOLD, hold_cnt=0, div_rst_n=0.
  - bclk_max=DEF_BCLK_MAX, lrck_max=DEF_LRCK_MAX.
  - cfg_ready=0, switching=1, done=0, timeout_err=0, lrck_d=0.
- After reset release, HOLD runs HOLD_CYCLES cycles, then IDLE. No done pulse after this startup HOLD.
- lrck_d <= lrck_q every cycle.
- Frame boundary (fe) = lrck_d & ~lrck_q.
- Acceptance: cfg_valid & cfg_ready on a rising edge.
  - cfg_ready=1 only in IDLE, and it is a registered output.
  - cfg_valid outside IDLE is ignored, not queued.
  - Accept captures cfg_bclk_max/cfg_lrck_max into pending registers and clears timeout_err.
- IDLE:
  - If the accepted values equal the current bclk_max/lrck_max, stay in IDLE and pulse done the next cycle. div_rst_n stays 1.
  - Otherwise go to DRAIN with to_cnt=0.
- DRAIN:
  - div_rst_n stays 1; to_cnt increments each cycle.
  - If fe: next state HOLD.
  - Else if to_cnt==TIMEOUT-1: set timeout_err, next state HOLD.
  - If fe and timeout coincide, fe wins and timeout_err is not set.
- Entering HOLD from DRAIN: on the same edge, div_rst_n<=0, bclk_max<=pending, lrck_max<=pending, hold_cnt<=0.
- HOLD:
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES-1: next state IDLE, div_rst_n<=1, cfg_ready<=1.
  - done<=1 for one cycle, except on the startup HOLD.
- Timing for a normal switch: accept at edge k, DRAIN from k+1. If fe is seen in cycle j, div_rst_n is low for cycles j+1..j+HOLD_CYCLES. IDLE and done fall on cycle j+HOLD_CYCLES+1.
- bclk_max/lrck_max change only at the HOLD-entry edge. They are never changed while div_rst_n=1.
- Reset mid-DRAIN or mid-HOLD: pending values are discarded and the outputs return to the reset defaults and the startup HOLD.
- Counters: to_cnt is 16-bit and saturates at TIMEOUT-1. hold_cnt is 8-bit.

Test Plan:
- Startup: reset release -> div_rst_n=0 for exactly 4 cycles; then cfg_ready=1, switching=0, bclk_max=3, lrck_max=127, done never pulses.
- Normal switch: lrck_q toggling; offer bclk=1, lrck=63 -> accepted in one cycle. On the first 1->0 of lrck_q, the next edge shows div_rst_n=0 and the maxes =1/63. div_rst_n is low 4 cycles, then done pulses once and cfg_ready=1.
- Identical config: offer 3/127 from IDLE -> no DRAIN, div_rst_n stays 1, done pulses the cycle after accept.
- Timeout: lrck_q held 0; offer 7/31 with TIMEOUT=16 -> HOLD entered after 16 DRAIN cycles, timeout_err=1. Next accepted config clears timeout_err.
- Busy rejection: cfg_valid held high with 9/9 during DRAIN and HOLD of a 1/63 switch -> 1/63 is applied. 9/9 is accepted only on the first IDLE cycle, where cfg_ready=1.
- Reset mid-DRAIN: assert reset_n=0 while in DRAIN -> outputs immediately return to 3/127, div_rst_n=0, pending discarded, startup HOLD repeats.
